bus_xbar_rr: RTL

//  Parametrised N-host to M-device memory-bus interconnect for the ibex-style req/gnt/rvalid protocol.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_outstanding_fifo.sv | 55 +++++
 rtl/bus_xbar_rr.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus widths and the outstanding-response bookkeeping entry.
package bus_pkg;

    localparam int unsigned BusAddrW = 32;
    localparam int unsigned BusDataW = 32;
    localparam int unsigned BusBeW   = 4;

    // Index fields are sized for up to 256 hosts/devices.
    localparam int unsigned RspIdxW  = 8;

    typedef struct packed {
        logic [RspIdxW-1:0] host;
        logic [RspIdxW-1:0] dev;
        logic               err;
    } rsp_entry_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_outstanding_fifo.sv
// Synchronous FIFO of outstanding responses: who asked, which device answers.
module bus_outstanding_fifo
    import bus_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  rsp_entry_t push_entry,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output rsp_entry_t head
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    rsp_entry_t      mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/bus_xbar_rr.sv
// N-host to M-device req/gnt/rvalid interconnect: round-robin arbitration,
// base/mask decode with decode-error responses, in-order response routing.
module bus_xbar_rr
    import bus_pkg::*;
#(
    parameter int unsigned                NrHosts        = 2,
    parameter int unsigned                NrDevices      = 2,
    parameter int unsigned                MaxOutstanding = 2,
    parameter logic [NrDevices*32-1:0]    DevBase        = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NrDevices*32-1:0]    DevMask        = {32'h0000_0FFF, 32'h0000_FFFF}
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NrHosts-1:0]            host_req_i,
    output logic [NrHosts-1:0]            host_gnt_o,
    input  logic [NrHosts*BusAddrW-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]            host_we_i,
    input  logic [NrHosts*BusBeW-1:0]     host_be_i,
    input  logic [NrHosts*BusDataW-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]            host_rvalid_o,
    output logic [NrHosts*BusDataW-1:0]   host_rdata_o,
    output logic [NrHosts-1:0]            host_err_o,
    output logic [NrDevices-1:0]          device_req_o,
    output logic [BusAddrW-1:0]           device_addr_o,
    output logic                          device_we_o,
    output logic [BusBeW-1:0]             device_be_o,
    output logic [BusDataW-1:0]           device_wdata_o,
    input  logic [NrDevices-1:0]          device_gnt_i,
    input  logic [NrDevices-1:0]          device_rvalid_i,
    input  logic [NrDevices*BusDataW-1:0] device_rdata_i,
    input  logic [NrDevices-1:0]          device_err_i
);

    localparam int unsigned HostIdxW = idx_width(NrHosts);
    localparam int unsigned DevIdxW  = idx_width(NrDevices);

    logic [HostIdxW-1:0] ptr;
    logic [HostIdxW-1:0] winner;
    logic                any_req;
    logic [BusAddrW-1:0] win_addr;
    logic                win_we;
    logic [BusBeW-1:0]   win_be;
    logic [BusDataW-1:0] win_wdata;
    logic                dec_hit;
    logic [DevIdxW-1:0]  dec_dev;
    logic                handshake;
    rsp_entry_t          push_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    rsp_entry_t          fifo_head;
    logic                rsp_valid;
    logic                rsp_err;
    logic [BusDataW-1:0] rsp_data;
    logic [NrDevices-1:0] accept_mask;
    logic                stray_rvalid;

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            if (!any_req && host_req_i[(32'(ptr) + i) % NrHosts]) begin
                any_req = 1'b1;
                winner  = HostIdxW'((32'(ptr) + i) % NrHosts);
            end
        end
    end

    // Select the winning host's request payload.
    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (HostIdxW'(h) == winner) begin
                win_addr  = host_addr_i[h*BusAddrW +: BusAddrW];
                win_we    = host_we_i[h];
                win_be    = host_be_i[h*BusBeW +: BusBeW];
                win_wdata = host_wdata_i[h*BusDataW +: BusDataW];
            end
        end
    end

    // Address decode; the lowest-indexed matching device wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_dev = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!dec_hit &&
                ((win_addr & ~DevMask[d*BusAddrW +: BusAddrW]) == DevBase[d*BusAddrW +: BusAddrW])) begin
                dec_hit = 1'b1;
                dec_dev = DevIdxW'(d);
            end
        end
    end

    // Issue to the decoded device, or self-grant on a decode error.
    always_comb begin
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        host_gnt_o     = '0;
        handshake      = 1'b0;
        push_entry     = '0;
        if (rst_ni && any_req && !fifo_full) begin
            if (dec_hit) begin
                for (int unsigned d = 0; d < NrDevices; d++) begin
                    if (DevIdxW'(d) == dec_dev) begin
                        device_req_o[d] = 1'b1;
                        handshake       = device_gnt_i[d];
                    end
                end
                device_addr_o  = win_addr;
                device_we_o    = win_we;
                device_be_o    = win_be;
                device_wdata_o = win_wdata;
            end else begin
                handshake = 1'b1;
            end
            for (int unsigned h = 0; h < NrHosts; h++) begin
                if (HostIdxW'(h) == winner) host_gnt_o[h] = handshake;
            end
            push_entry.host = RspIdxW'(winner);
            push_entry.dev  = dec_hit ? RspIdxW'(dec_dev) : '0;
            push_entry.err  = ~dec_hit;
        end
    end

    // Priority moves past the winner only once its request is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= (winner == HostIdxW'(NrHosts - 1)) ? '0 : winner + HostIdxW'(1);
        end
    end

    bus_outstanding_fifo #(
        .Depth (MaxOutstanding)
    ) u_outstanding (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (handshake),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    // Head-of-line response: decode errors retire at once, others wait for their device.
    always_comb begin
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = '0;
        accept_mask = '0;
        if (!fifo_empty) begin
            if (fifo_head.err) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                for (int unsigned d = 0; d < NrDevices; d++) begin
                    if (RspIdxW'(d) == fifo_head.dev) begin
                        accept_mask[d] = 1'b1;
                        if (device_rvalid_i[d]) begin
                            rsp_valid = 1'b1;
                            rsp_err   = device_err_i[d];
                            rsp_data  = device_err_i[d] ? '0 : device_rdata_i[d*BusDataW +: BusDataW];
                        end
                    end
                end
            end
        end
    end

    assign fifo_pop = rsp_valid;

    // Route the retiring response to the host that issued it.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (rsp_valid && (RspIdxW'(h) == fifo_head.host)) begin
                host_rvalid_o[h]                     = 1'b1;
                host_err_o[h]                        = rsp_err;
                host_rdata_o[h*BusDataW +: BusDataW] = rsp_data;
            end
        end
    end

    assign stray_rvalid = |(device_rvalid_i & ~accept_mask);

    // A device answering out of turn has its response dropped.
    ignored_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !stray_rvalid)
        else $warning("bus_xbar_rr: device rvalid dropped, not owed by the head outstanding entry");

endmodule
